// File: rtl/spi_data_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_data_responder
// Purpose  : SPI slave that answers a command byte with a header, a video
//            section and an audio section, fed through a one-byte prefetch.
// Revision : 1.0
// ============================================================================
module spi_data_responder #(
    parameter logic [7:0] CMD_BYTE    = 8'hAA,
    parameter logic [7:0] HDR_BYTE    = 8'hFF,
    parameter int         VIDEO_BYTES = 38400,
    parameter int         AUDIO_BYTES = 1024
) (
    input  logic       CLK_40,
    input  logic       reset_n,
    input  logic       SPI_clk_en,
    input  logic       chip_select,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    output logic       src_sel,
    output logic       busy,
    output logic       frame_sent,
    output logic       underrun
);
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CMD_RX   = 3'd1;
    localparam logic [2:0] c_HDR_TX   = 3'd2;
    localparam logic [2:0] c_VIDEO_TX = 3'd3;
    localparam logic [2:0] c_AUDIO_TX = 3'd4;
    localparam logic [2:0] c_WAIT_CS  = 3'd5;

    localparam logic [15:0] c_VID_N = 16'(VIDEO_BYTES);
    localparam logic [15:0] c_AUD_N = 16'(AUDIO_BYTES);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_cmd;
    logic [7:0]  r_shift;
    logic [7:0]  r_pf_data;
    logic        r_pf_valid;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_vid_taken;
    logic [15:0] r_aud_taken;
    logic        r_miso;
    logic        r_frame_sent;
    logic        r_underrun;

    logic       w_active;
    logic       w_payload;
    logic       w_abort;
    logic       w_strobe;
    logic       w_boundary;
    logic       w_last_bit;
    logic       w_sec_aud;
    logic       w_room;
    logic       w_clear;
    logic [7:0] w_load;

    assign w_active   = (r_state == c_HDR_TX) || w_payload;
    assign w_payload  = (r_state == c_VIDEO_TX) || (r_state == c_AUDIO_TX);
    assign w_abort    = chip_select && (w_active || (r_state == c_CMD_RX));
    assign w_strobe   = SPI_clk_en && !chip_select;
    assign w_boundary = w_strobe && w_payload && (r_bit_cnt == 3'd0);
    assign w_last_bit = (r_bit_cnt == 3'd7);
    // "taken" counts fetched bytes plus underrun slots, so a skipped byte
    // consumes its section budget and is never replaced.
    assign w_sec_aud  = (r_vid_taken == c_VID_N);
    assign w_room     = w_sec_aud ? (r_aud_taken != c_AUD_N) : 1'b1;
    assign w_clear    = w_abort || ((r_state == c_WAIT_CS) && chip_select);
    assign w_load     = r_pf_valid ? r_pf_data : 8'h00;

    always_ff @(posedge CLK_40) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:     if (w_strobe) w_next = c_CMD_RX;
                c_CMD_RX:   if (w_strobe && w_last_bit)
                                w_next = ({MOSI, r_cmd} == CMD_BYTE) ? c_HDR_TX : c_WAIT_CS;
                c_HDR_TX:   if (w_strobe && w_last_bit) w_next = c_VIDEO_TX;
                c_VIDEO_TX: if (w_strobe && w_last_bit && (r_byte_cnt == c_VID_N)) w_next = c_AUDIO_TX;
                c_AUDIO_TX: if (w_strobe && w_last_bit && (r_byte_cnt == c_AUD_N)) w_next = c_WAIT_CS;
                c_WAIT_CS:  if (chip_select) w_next = c_IDLE;
                default:    w_next = c_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = reset_n && (r_state != c_IDLE);
        src_sel   = reset_n && (r_state != c_IDLE) && w_sec_aud;
        // Fetching is held off on a boundary strobe so the prefetch is never
        // loaded and drained in the same cycle.
        src_ready = reset_n && w_active && !chip_select && !r_pf_valid &&
                    src_valid && w_room && !w_boundary;
    end

    always_ff @(posedge CLK_40) begin
        if (!reset_n) begin
            r_bit_cnt    <= '0;
            r_cmd        <= '0;
            r_shift      <= '0;
            r_pf_data    <= '0;
            r_pf_valid   <= 1'b0;
            r_byte_cnt   <= '0;
            r_vid_taken  <= '0;
            r_aud_taken  <= '0;
            r_miso       <= 1'b0;
            r_frame_sent <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_frame_sent <= (r_state == c_AUDIO_TX) && (w_next == c_WAIT_CS);
            r_underrun   <= w_boundary && !r_pf_valid;
            if (w_clear) begin
                r_bit_cnt   <= '0;
                r_pf_valid  <= 1'b0;
                r_byte_cnt  <= '0;
                r_vid_taken <= '0;
                r_aud_taken <= '0;
                r_miso      <= 1'b0;
            end else begin
                if (src_ready) begin
                    r_pf_valid <= 1'b1;
                    r_pf_data  <= src_data;
                    if (w_sec_aud) r_aud_taken <= r_aud_taken + 16'd1;
                    else           r_vid_taken <= r_vid_taken + 16'd1;
                end
                if (w_strobe) begin
                    case (r_state)
                        c_IDLE: begin
                            r_cmd     <= {MOSI, r_cmd[6:1]};
                            r_bit_cnt <= 3'd1;
                        end
                        c_CMD_RX: begin
                            r_cmd     <= {MOSI, r_cmd[6:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= HDR_BYTE;
                        end
                        c_HDR_TX: begin
                            r_miso    <= r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        c_VIDEO_TX, c_AUDIO_TX: begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd0) begin
                                r_miso     <= w_load[7];
                                r_shift    <= {w_load[6:0], 1'b0};
                                r_pf_valid <= 1'b0;
                                r_byte_cnt <= r_byte_cnt + 16'd1;
                                if (!r_pf_valid) begin
                                    if (r_state == c_VIDEO_TX) r_vid_taken <= r_vid_taken + 16'd1;
                                    else                       r_aud_taken <= r_aud_taken + 16'd1;
                                end
                            end else begin
                                r_miso  <= r_shift[7];
                                r_shift <= {r_shift[6:0], 1'b0};
                                if (w_last_bit && (r_state == c_VIDEO_TX) && (r_byte_cnt == c_VID_N))
                                    r_byte_cnt <= '0;
                            end
                        end
                        c_WAIT_CS: r_miso <= 1'b0;
                        default:   r_miso <= 1'b0;
                    endcase
                end
            end
        end
    end

    assign MISO       = r_miso;
    assign frame_sent = r_frame_sent;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_data_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_data_responder
// Purpose  : Self-checking bench: scenario table plus randomized frames,
//            compared against a slot/window model of the frame contents.
// Revision : 1.0
// ============================================================================
module tb_spi_data_responder;
    localparam logic [7:0] c_CMD = 8'hAA;
    localparam logic [7:0] c_HDR = 8'hFF;
    localparam int         c_NV  = 4;
    localparam int         c_NA  = 2;
    localparam int         c_NS  = 76;

    logic       CLK_40 = 1'b0;
    logic       reset_n = 1'b0;
    logic       SPI_clk_en = 1'b0;
    logic       chip_select = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] src_data;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic       src_sel;
    logic       busy;
    logic       frame_sent;
    logic       underrun;

    logic [7:0] vid_q [256];
    logic [7:0] aud_q [256];
    logic [7:0] vi = 8'd0;
    logic [7:0] ai = 8'd0;
    int n_cmp = 0;
    int n_bad = 0;
    int nu, nf, pv, pa;

    typedef struct {
        logic [7:0] cmd;
        int         gap;
        int         vpct;
        int         hole;
        int         abort_s;
        int         rst_s;
        int         exp_fs;
    } row_t;

    row_t tbl [12];

    always #5 CLK_40 = ~CLK_40;

    assign src_data = src_sel ? aud_q[ai] : vid_q[vi];

    spi_data_responder #(
        .CMD_BYTE(c_CMD), .HDR_BYTE(c_HDR), .VIDEO_BYTES(c_NV), .AUDIO_BYTES(c_NA)
    ) dut (
        .CLK_40(CLK_40), .reset_n(reset_n), .SPI_clk_en(SPI_clk_en),
        .chip_select(chip_select), .MOSI(MOSI), .MISO(MISO),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_sel(src_sel), .busy(busy), .frame_sent(frame_sent), .underrun(underrun)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle; the bench-side source pops on an accepted handshake.
    task automatic cyc(input logic en, input logic cs, input logic mosi,
                       input logic rn, input logic v);
        logic hs, sel;
        @(negedge CLK_40);
        SPI_clk_en = en; chip_select = cs; MOSI = mosi; reset_n = rn; src_valid = v;
        #1;
        hs  = src_ready && src_valid;
        sel = src_sel;
        @(posedge CLK_40);
        #1;
        if (hs) begin
            if (sel) begin ai = ai + 8'd1; pa++; end
            else     begin vi = vi + 8'd1; pv++; end
        end
        if (underrun)   nu++;
        if (frame_sent) nf++;
    endtask

    task automatic xfer(input row_t r, input int id);
        logic [0:67] got, exp;
        logic [7:0]  b, gb, eb, mv, ma, hdr;
        bit          avail [6];
        bit          win, bnd, stopped, v;
        int          w, nobs, stop, lim, eu, ev, ea;
        nu = 0; nf = 0; pv = 0; pa = 0;
        mv = vi; ma = ai; hdr = c_HDR;
        win = 0; w = 0; nobs = 0; stopped = 0; got = '0;
        foreach (avail[k]) avail[k] = 0;
        stop = (r.abort_s > 0) ? r.abort_s : r.rst_s;
        for (int s = 1; s <= c_NS && !stopped; s++) begin
            for (int g = 1; g < r.gap; g++) begin
                v = ($urandom_range(99) < r.vpct) && !(win && w == r.hole);
                if (win && v && w < 6) avail[w] = 1;
                cyc(1'b0, 1'b0, 1'b0, 1'b1, v);
            end
            if (s == stop) begin
                if (r.abort_s > 0) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
                else               cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
                chk($sformatf("row%0d stop_outputs", id),
                    {26'd0, busy, MISO, src_ready, src_sel, frame_sent, underrun}, 32'd0);
                stopped = 1;
            end else begin
                bnd = (s >= 17) && ((s - 17) % 8 == 0) && ((s - 17) / 8 < 6);
                v = ($urandom_range(99) < r.vpct) && !(win && w == r.hole);
                if (win && v && w < 6 && !bnd) avail[w] = 1;
                cyc(1'b1, 1'b0, (s <= 8) ? r.cmd[s-1] : 1'b0, 1'b1, v);
                if (s >= 9) begin got[s-9] = MISO; nobs++; end
                if (s == 8 && r.cmd == c_CMD) win = 1;
                if (win && bnd) w++;
            end
        end
        if (stopped) begin
            if (r.rst_s > 0) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end else begin
            chk($sformatf("row%0d busy_wait_cs", id), {31'd0, busy}, 32'd1);
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("row%0d busy_idle", id), {31'd0, busy}, 32'd0);
        end
        // Model: slot k carries the next source byte if the source offered one
        // during its fetch window, otherwise 0x00 with an underrun.
        exp = '0; eu = 0; ev = 0; ea = 0;
        lim = stopped ? stop : c_NS + 1;
        if (r.cmd == c_CMD) begin
            for (int i = 0; i < 8; i++) exp[i] = hdr[7-i];
            for (int k = 0; k < 6; k++) begin
                if (avail[k]) begin
                    if (k < c_NV) begin b = vid_q[mv]; mv = mv + 8'd1; ev++; end
                    else          begin b = aud_q[ma]; ma = ma + 8'd1; ea++; end
                end else begin
                    b = 8'h00;
                    if (17 + 8 * k < lim) eu++;
                end
                for (int i = 0; i < 8; i++) exp[8 + 8*k + i] = b[7-i];
            end
        end
        for (int c = 0; c < 9; c++) begin
            if (nobs > 8 * c) begin
                gb = '0; eb = '0;
                for (int i = 0; i < 8; i++) begin
                    if (8*c + i < nobs) begin
                        gb[7-i] = got[8*c + i];
                        eb[7-i] = exp[8*c + i];
                    end
                end
                chk($sformatf("row%0d miso_byte%0d", id, c), {24'd0, gb}, {24'd0, eb});
            end
        end
        chk($sformatf("row%0d underruns", id), nu, eu);
        chk($sformatf("row%0d frame_sent", id), nf, r.exp_fs);
        chk($sformatf("row%0d video_fetches", id), pv, ev);
        chk($sformatf("row%0d audio_fetches", id), pa, ea);
    endtask

    initial begin
        row_t rr;
        for (int i = 0; i < 256; i++) begin
            vid_q[i] = 8'($urandom);
            aud_q[i] = 8'($urandom);
        end
        tbl[0]  = '{8'hAA, 1, 100, -1,  0,  0, 1};
        tbl[1]  = '{8'hAA, 4, 100, -1,  0,  0, 1};
        tbl[2]  = '{8'hAB, 1, 100, -1,  0,  0, 0};
        tbl[3]  = '{8'hAA, 2, 100,  2,  0,  0, 1};
        tbl[4]  = '{8'hAA, 1, 100, -1, 35,  0, 0};
        tbl[5]  = '{8'hAA, 1, 100, -1,  0,  0, 1};
        tbl[6]  = '{8'hAA, 1, 100, -1, 16,  0, 0};
        tbl[7]  = '{8'hAA, 3, 100, -1,  0,  0, 1};
        tbl[8]  = '{8'hAA, 1, 100, -1,  0, 51, 0};
        tbl[9]  = '{8'hAA, 1, 100, -1,  0,  0, 1};
        tbl[10] = '{8'hAA, 1, 100, -1, 64,  0, 0};
        tbl[11] = '{8'hAA, 2,  60, -1,  0,  0, 1};

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("reset_outputs", {26'd0, busy, MISO, src_ready, src_sel, frame_sent, underrun}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 12; i++) xfer(tbl[i], i);

        for (int i = 0; i < 8; i++) begin
            rr.cmd     = ($urandom_range(3) == 0) ? 8'($urandom) : c_CMD;
            rr.gap     = $urandom_range(4, 1);
            rr.vpct    = $urandom_range(100, 20);
            rr.hole    = -1;
            rr.abort_s = 0;
            rr.rst_s   = 0;
            rr.exp_fs  = (rr.cmd == c_CMD) ? 1 : 0;
            xfer(rr, 100 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
